axi_buf: RTL and testbench
==========================

# axi_buf

Parametrised AXI buffer between two `axi_channel` interfaces, with an independently sized FIFO on each of the five channels (AW, W, B, AR, R). It cuts timing paths and absorbs bursts between interconnect stages. A channel configured with depth 0 reduces to a plain combinational wire-through. Beyond that, it optionally widens the transaction ID from the master side to the slave side.

## Interface
- `AW_DEPTH`, default 2: AW FIFO entries. 0 means wire-through.
- `W_DEPTH`, default 2: W FIFO entries. 0 means wire-through.
- `B_DEPTH`, default 2: B FIFO entries. 0 means wire-through.
- `AR_DEPTH`, default 2: AR FIFO entries. 0 means wire-through.
- `R_DEPTH`, default 2: R FIFO entries. 0 means wire-through.
- `clk`  in  1: single clock for all channels.
- `rst`  in  1: reset, synchronous, active-high.
- `master`  `axi_channel.slave`  (from interface): upstream side. ID width is `IDM`.
- `slave`  `axi_channel.master`  (from interface): downstream side. ID width is `IDS`.

## Operation
- Elaboration-time checks (`$fatal`):
  - every depth parameter must be >= 0;
  - `IDS >= IDM`;
  - all other field widths (addr, data, user) must match exactly between the two sides.
- ID handling:
  - `slave.aw_id` and `slave.ar_id` are `master.*_id` zero-extended to `IDS` bits.
  - `master.b_id` and `master.r_id` are the low `IDM` bits of `slave.*_id`.
- Channel payload is all fields of the channel except valid and ready, concatenated. Payload and order pass unchanged.
- Channel direction:
  - forward channels (AW, W, AR): input is `master`, output is `slave`;
  - reverse channels (B, R): input is `slave`, output is `master`.
- DEPTH = 0: `out_valid = in_valid`, `out_payload = in_payload`, `in_ready = out_ready`. No state.
- DEPTH = D >= 1: circular FIFO with read pointer, write pointer and a count register in 0..D.
  - `in_ready = (count < D) && !rst`. It is registered-derived and has no combinational path from `out_ready`.
  - `out_valid = (count != 0)`.
  - `out_payload` is the entry at the read pointer.
  - Push when `in_valid && in_ready`: write the entry at the write pointer, then advance the write pointer.
  - Pop when `out_valid && out_ready`: advance the read pointer.
  - Pointers wrap from D-1 to 0. D need not be a power of two.
  - Count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- D = 1 gives at most one transfer every 2 cycles. D >= 2 sustains one transfer per cycle.
- Channels are fully independent. No AW/W or AR/R coupling is added, and no reordering is introduced.
- The payload at the output must stay stable while `out_valid && !out_ready`. This follows from FIFO semantics.

## Timing
- Reset (`rst` high at a rising `clk`) sets every count and pointer to 0. Storage contents are not reset.
- While `rst` is high:
  - every FIFO-side `in_ready` = 0 and every FIFO-side `out_valid` = 0;
  - no push or pop occurs.
- In the first cycle after `rst` falls, every `in_ready` = 1 (D >= 1) and every `out_valid` = 0.
- Reset mid-operation discards all buffered beats and bursts without notice. Upstream and downstream must be reset together.
- Latency for D >= 1: a beat pushed at edge N appears with `out_valid` = 1 in the cycle after edge N, i.e. 1 cycle. There is no same-cycle fall-through.
- Latency for D = 0: 0 cycles.
- Full (count = D): `in_ready` = 0 on the next cycle even if `out_ready` = 1. A pop in that cycle re-opens `in_ready` one cycle later.
- Empty (count = 0): `out_valid` = 0. A push and the output of that same beat never occur in the same cycle.

## Test plan
1. Reset:
   - hold `rst` 3 cycles with `master.aw_valid` = 1 -> `master.aw_ready` = 0 and `slave.aw_valid` = 0 throughout, nothing accepted;
   - release -> `aw_ready` = 1 next cycle.
2. Throughput at D = 2:
   - stream 16 W beats (data 0..15, `w_last` on 15) with `slave.w_ready` tied 1 -> one beat per cycle, 1-cycle latency, order 0..15 preserved, `w_last` only on beat 15;
   - at D = 1 the same stimulus -> a transfer every 2 cycles.
3. Backpressure and wrap:
   - D = 3, `slave.ar_ready` = 0, push 4 ARs -> 3 accepted, `master.ar_ready` falls after the 3rd;
   - release, then push 10 more -> all 13 emerge in order with no loss or duplication, exercising pointer wrap at 3.
4. Random valid/ready on all five channels, all depths in {0,1,2,5} -> scoreboard shows in-order, lossless, payload-exact transfer, and the output payload is stable whenever valid is high and ready is low.
5. ID widening, `IDM` = 4 and `IDS` = 6:
   - `aw_id` = 4'hA -> `slave.aw_id` = 6'h0A;
   - `slave.b_id` = 6'h35 -> `master.b_id` = 4'h5.
6. Mid-burst reset: R FIFO holding 2 beats, assert `rst` 1 cycle -> `master.r_valid` = 0 afterwards and count = 0, with no stale beats emitted once reset is released.

Source files
------------

// File: rtl/axi_buf_if.sv
// Full AXI channel bundle (AW, W, B, AR, R) shared by both sides of axi_buf.
// Each instance sets its own ID width, so the two sides of a buffer may differ.
interface axi_channel #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int USER_W = 1
);
  logic [ID_W-1:0]     aw_id;
  logic [ADDR_W-1:0]   aw_addr;
  logic [7:0]          aw_len;
  logic [2:0]          aw_size;
  logic [1:0]          aw_burst;
  logic [USER_W-1:0]   aw_user;
  logic                aw_valid;
  logic                aw_ready;

  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                w_last;
  logic [USER_W-1:0]   w_user;
  logic                w_valid;
  logic                w_ready;

  logic [ID_W-1:0]     b_id;
  logic [1:0]          b_resp;
  logic [USER_W-1:0]   b_user;
  logic                b_valid;
  logic                b_ready;

  logic [ID_W-1:0]     ar_id;
  logic [ADDR_W-1:0]   ar_addr;
  logic [7:0]          ar_len;
  logic [2:0]          ar_size;
  logic [1:0]          ar_burst;
  logic [USER_W-1:0]   ar_user;
  logic                ar_valid;
  logic                ar_ready;

  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_resp;
  logic                r_last;
  logic [USER_W-1:0]   r_user;
  logic                r_valid;
  logic                r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_buf.sv
// AXI buffer: one independently sized FIFO per channel, depth 0 = wire-through.
// Request IDs are zero-extended towards the slave, response IDs truncated back.

module axi_buf_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_payload,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_payload
);
  if (DEPTH <= 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk | rst;
    assign out_valid      = in_valid;
    assign out_payload    = in_payload;
    assign in_ready       = out_ready;
  end else begin : g_fifo
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Both flags come from the count register only, so in_ready never
    // depends combinationally on out_ready.
    assign in_ready    = (count < FULL) && !rst;
    assign out_valid   = (count != '0) && !rst;
    assign out_payload = mem[rd_ptr];
    assign push        = in_valid && in_ready;
    assign pop         = out_valid && out_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
    end

    // NOTE: storage is deliberately left out of reset; count gates every read,
    // so stale entries are never visible and the array can map to plain RAM.
    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_payload;
    end
  end
endmodule

module axi_buf #(
  parameter int AW_DEPTH = 2,
  parameter int W_DEPTH  = 2,
  parameter int B_DEPTH  = 2,
  parameter int AR_DEPTH = 2,
  parameter int R_DEPTH  = 2
) (
  input  logic       clk,
  input  logic       rst,
  axi_channel.slave  master,
  axi_channel.master slave
);
  localparam int IDM    = $bits(master.aw_id);
  localparam int IDS    = $bits(slave.aw_id);
  localparam int ADDR_W = $bits(master.aw_addr);
  localparam int DATA_W = $bits(master.w_data);
  localparam int STRB_W = $bits(master.w_strb);
  localparam int USER_W = $bits(master.aw_user);

  localparam int AX_W = IDM + ADDR_W + 8 + 3 + 2 + USER_W;
  localparam int W_W  = DATA_W + STRB_W + 1 + USER_W;
  localparam int B_W  = IDM + 2 + USER_W;
  localparam int R_W  = IDM + DATA_W + 2 + 1 + USER_W;

  if (AW_DEPTH < 0 || W_DEPTH < 0 || B_DEPTH < 0 || AR_DEPTH < 0 || R_DEPTH < 0)
  begin : g_bad_depth
    $fatal(1, "axi_buf: FIFO depths must be >= 0");
  end
  if (IDS < IDM) begin : g_bad_id
    $fatal(1, "axi_buf: slave-side ID narrower than master-side ID");
  end
  if ($bits(slave.aw_addr) != ADDR_W || $bits(slave.w_data) != DATA_W ||
      $bits(slave.aw_user) != USER_W) begin : g_bad_width
    $fatal(1, "axi_buf: addr/data/user widths differ between sides");
  end

  // Only the low IDM bits of response IDs travel back upstream.
  logic unused_id_bits;
  assign unused_id_bits = ^{slave.b_id, slave.r_id};

  // AW: master -> slave
  logic [AX_W-1:0] aw_in, aw_out;
  logic [IDM-1:0]  aw_id_out;
  assign aw_in = {master.aw_id, master.aw_addr, master.aw_len, master.aw_size,
                  master.aw_burst, master.aw_user};
  assign {aw_id_out, slave.aw_addr, slave.aw_len, slave.aw_size,
          slave.aw_burst, slave.aw_user} = aw_out;
  assign slave.aw_id = IDS'(aw_id_out);

  axi_buf_fifo #(.DEPTH(AW_DEPTH), .WIDTH(AX_W)) u_aw_fifo (
    .clk(clk), .rst(rst),
    .in_valid(master.aw_valid), .in_ready(master.aw_ready), .in_payload(aw_in),
    .out_valid(slave.aw_valid), .out_ready(slave.aw_ready), .out_payload(aw_out)
  );

  // W: master -> slave
  logic [W_W-1:0] w_in, w_out;
  assign w_in = {master.w_data, master.w_strb, master.w_last, master.w_user};
  assign {slave.w_data, slave.w_strb, slave.w_last, slave.w_user} = w_out;

  axi_buf_fifo #(.DEPTH(W_DEPTH), .WIDTH(W_W)) u_w_fifo (
    .clk(clk), .rst(rst),
    .in_valid(master.w_valid), .in_ready(master.w_ready), .in_payload(w_in),
    .out_valid(slave.w_valid), .out_ready(slave.w_ready), .out_payload(w_out)
  );

  // B: slave -> master
  logic [B_W-1:0] b_in, b_out;
  assign b_in = {slave.b_id[IDM-1:0], slave.b_resp, slave.b_user};
  assign {master.b_id, master.b_resp, master.b_user} = b_out;

  axi_buf_fifo #(.DEPTH(B_DEPTH), .WIDTH(B_W)) u_b_fifo (
    .clk(clk), .rst(rst),
    .in_valid(slave.b_valid), .in_ready(slave.b_ready), .in_payload(b_in),
    .out_valid(master.b_valid), .out_ready(master.b_ready), .out_payload(b_out)
  );

  // AR: master -> slave
  logic [AX_W-1:0] ar_in, ar_out;
  logic [IDM-1:0]  ar_id_out;
  assign ar_in = {master.ar_id, master.ar_addr, master.ar_len, master.ar_size,
                  master.ar_burst, master.ar_user};
  assign {ar_id_out, slave.ar_addr, slave.ar_len, slave.ar_size,
          slave.ar_burst, slave.ar_user} = ar_out;
  assign slave.ar_id = IDS'(ar_id_out);

  axi_buf_fifo #(.DEPTH(AR_DEPTH), .WIDTH(AX_W)) u_ar_fifo (
    .clk(clk), .rst(rst),
    .in_valid(master.ar_valid), .in_ready(master.ar_ready), .in_payload(ar_in),
    .out_valid(slave.ar_valid), .out_ready(slave.ar_ready), .out_payload(ar_out)
  );

  // R: slave -> master
  logic [R_W-1:0] r_in, r_out;
  assign r_in = {slave.r_id[IDM-1:0], slave.r_data, slave.r_resp, slave.r_last,
                 slave.r_user};
  assign {master.r_id, master.r_data, master.r_resp, master.r_last,
          master.r_user} = r_out;

  axi_buf_fifo #(.DEPTH(R_DEPTH), .WIDTH(R_W)) u_r_fifo (
    .clk(clk), .rst(rst),
    .in_valid(slave.r_valid), .in_ready(slave.r_ready), .in_payload(r_in),
    .out_valid(master.r_valid), .out_ready(master.r_ready), .out_payload(r_out)
  );
endmodule

// File: tb/tb_axi_buf.sv
// Scoreboard bench for axi_buf: two instances with mixed depths (0,1,2,3,5) and
// IDM=4 / IDS=6; every channel is flattened to a 64-bit in/expected/observed word.
module tb_axi_buf;
  logic clk;
  logic rst;

  axi_channel #(.ID_W(4), .ADDR_W(16), .DATA_W(16), .USER_W(2)) m_a ();
  axi_channel #(.ID_W(6), .ADDR_W(16), .DATA_W(16), .USER_W(2)) s_a ();
  axi_channel #(.ID_W(4), .ADDR_W(16), .DATA_W(16), .USER_W(2)) m_b ();
  axi_channel #(.ID_W(6), .ADDR_W(16), .DATA_W(16), .USER_W(2)) s_b ();

  axi_buf #(.AW_DEPTH(2), .W_DEPTH(2), .B_DEPTH(0), .AR_DEPTH(3), .R_DEPTH(5))
    u_dut_a (.clk(clk), .rst(rst), .master(m_a), .slave(s_a));
  axi_buf #(.AW_DEPTH(1), .W_DEPTH(1), .B_DEPTH(2), .AR_DEPTH(0), .R_DEPTH(2))
    u_dut_b (.clk(clk), .rst(rst), .master(m_b), .slave(s_b));

  // Channel index: 0..4 = a.{aw,w,b,ar,r}, 5..9 = b.{aw,w,b,ar,r}.
  localparam logic [9:0] DZ = 10'b01_0000_0100;  // wire-through channels
  string names [10] = '{"a.aw", "a.w", "a.b", "a.ar", "a.r",
                        "b.aw", "b.w", "b.b", "b.ar", "b.r"};

  logic [9:0][63:0] drv;
  logic [9:0]       iv, ordy;
  wire  [9:0]       irdy, ov;
  wire  [9:0][63:0] obs, expw;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] sb_q [10][$];
  logic [9:0]       fired_in = '0;
  logic [9:0]       stall    = '0;
  logic [9:0][63:0] held;

  // ---- channel wiring, instance a ----
  assign {m_a.aw_id, m_a.aw_addr, m_a.aw_len, m_a.aw_size, m_a.aw_burst, m_a.aw_user} = drv[0][34:0];
  assign m_a.aw_valid = iv[0];  assign s_a.aw_ready = ordy[0];
  assign irdy[0] = m_a.aw_ready; assign ov[0] = s_a.aw_valid;
  assign obs[0]  = {27'b0, s_a.aw_id, s_a.aw_addr, s_a.aw_len, s_a.aw_size, s_a.aw_burst, s_a.aw_user};
  assign expw[0] = {27'b0, 2'b00, drv[0][34:0]};

  assign {m_a.w_data, m_a.w_strb, m_a.w_last, m_a.w_user} = drv[1][20:0];
  assign m_a.w_valid = iv[1];   assign s_a.w_ready = ordy[1];
  assign irdy[1] = m_a.w_ready;  assign ov[1] = s_a.w_valid;
  assign obs[1]  = {43'b0, s_a.w_data, s_a.w_strb, s_a.w_last, s_a.w_user};
  assign expw[1] = {43'b0, drv[1][20:0]};

  assign {s_a.b_id, s_a.b_resp, s_a.b_user} = drv[2][9:0];
  assign s_a.b_valid = iv[2];   assign m_a.b_ready = ordy[2];
  assign irdy[2] = s_a.b_ready;  assign ov[2] = m_a.b_valid;
  assign obs[2]  = {56'b0, m_a.b_id, m_a.b_resp, m_a.b_user};
  assign expw[2] = {56'b0, drv[2][7:0]};

  assign {m_a.ar_id, m_a.ar_addr, m_a.ar_len, m_a.ar_size, m_a.ar_burst, m_a.ar_user} = drv[3][34:0];
  assign m_a.ar_valid = iv[3];  assign s_a.ar_ready = ordy[3];
  assign irdy[3] = m_a.ar_ready; assign ov[3] = s_a.ar_valid;
  assign obs[3]  = {27'b0, s_a.ar_id, s_a.ar_addr, s_a.ar_len, s_a.ar_size, s_a.ar_burst, s_a.ar_user};
  assign expw[3] = {27'b0, 2'b00, drv[3][34:0]};

  assign {s_a.r_id, s_a.r_data, s_a.r_resp, s_a.r_last, s_a.r_user} = drv[4][26:0];
  assign s_a.r_valid = iv[4];   assign m_a.r_ready = ordy[4];
  assign irdy[4] = s_a.r_ready;  assign ov[4] = m_a.r_valid;
  assign obs[4]  = {39'b0, m_a.r_id, m_a.r_data, m_a.r_resp, m_a.r_last, m_a.r_user};
  assign expw[4] = {39'b0, drv[4][24:0]};

  // ---- channel wiring, instance b ----
  assign {m_b.aw_id, m_b.aw_addr, m_b.aw_len, m_b.aw_size, m_b.aw_burst, m_b.aw_user} = drv[5][34:0];
  assign m_b.aw_valid = iv[5];  assign s_b.aw_ready = ordy[5];
  assign irdy[5] = m_b.aw_ready; assign ov[5] = s_b.aw_valid;
  assign obs[5]  = {27'b0, s_b.aw_id, s_b.aw_addr, s_b.aw_len, s_b.aw_size, s_b.aw_burst, s_b.aw_user};
  assign expw[5] = {27'b0, 2'b00, drv[5][34:0]};

  assign {m_b.w_data, m_b.w_strb, m_b.w_last, m_b.w_user} = drv[6][20:0];
  assign m_b.w_valid = iv[6];   assign s_b.w_ready = ordy[6];
  assign irdy[6] = m_b.w_ready;  assign ov[6] = s_b.w_valid;
  assign obs[6]  = {43'b0, s_b.w_data, s_b.w_strb, s_b.w_last, s_b.w_user};
  assign expw[6] = {43'b0, drv[6][20:0]};

  assign {s_b.b_id, s_b.b_resp, s_b.b_user} = drv[7][9:0];
  assign s_b.b_valid = iv[7];   assign m_b.b_ready = ordy[7];
  assign irdy[7] = s_b.b_ready;  assign ov[7] = m_b.b_valid;
  assign obs[7]  = {56'b0, m_b.b_id, m_b.b_resp, m_b.b_user};
  assign expw[7] = {56'b0, drv[7][7:0]};

  assign {m_b.ar_id, m_b.ar_addr, m_b.ar_len, m_b.ar_size, m_b.ar_burst, m_b.ar_user} = drv[8][34:0];
  assign m_b.ar_valid = iv[8];  assign s_b.ar_ready = ordy[8];
  assign irdy[8] = m_b.ar_ready; assign ov[8] = s_b.ar_valid;
  assign obs[8]  = {27'b0, s_b.ar_id, s_b.ar_addr, s_b.ar_len, s_b.ar_size, s_b.ar_burst, s_b.ar_user};
  assign expw[8] = {27'b0, 2'b00, drv[8][34:0]};

  assign {s_b.r_id, s_b.r_data, s_b.r_resp, s_b.r_last, s_b.r_user} = drv[9][26:0];
  assign s_b.r_valid = iv[9];   assign m_b.r_ready = ordy[9];
  assign irdy[9] = s_b.r_ready;  assign ov[9] = m_b.r_valid;
  assign obs[9]  = {39'b0, m_b.r_id, m_b.r_data, m_b.r_resp, m_b.r_last, m_b.r_user};
  assign expw[9] = {39'b0, drv[9][24:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] w_beat(input int i);
    return {43'b0, 16'(i), 2'b11, (i == 15), 2'b00};
  endfunction

  function automatic logic [63:0] ar_beat(input int i);
    return {29'b0, 4'(i), 16'(16'h0100 + i), 8'(i), 3'd2, 2'd1, 2'(i)};
  endfunction

  function automatic logic [63:0] r_beat(input int i);
    return {37'b0, 6'(i + 8), 16'(16'hA000 + i), 2'd0, (i == 1), 2'(i)};
  endfunction

  // Scoreboard/monitor: sampled mid-cycle, when all handshake signals are settled.
  always @(negedge clk) begin
    for (int c = 0; c < 10; c++) begin
      if (rst) begin
        if (!DZ[c]) begin
          check({names[c], ".rst_in_ready"}, 64'(irdy[c]), 64'd0);
          check({names[c], ".rst_out_valid"}, 64'(ov[c]), 64'd0);
        end
        sb_q[c].delete();
        stall[c]    = 1'b0;
        fired_in[c] = 1'b0;
      end else begin
        fired_in[c] = iv[c] && irdy[c];
        if (fired_in[c]) sb_q[c].push_back(expw[c]);
        if (stall[c]) begin
          check({names[c], ".stall_valid"}, 64'(ov[c]), 64'd1);
          check({names[c], ".stall_payload"}, obs[c], held[c]);
        end
        if (ov[c] && ordy[c]) begin
          check({names[c], ".beat_expected"}, 64'(sb_q[c].size() != 0), 64'd1);
          if (sb_q[c].size() != 0) check({names[c], ".payload"}, obs[c], sb_q[c].pop_front());
        end
        stall[c] = ov[c] && !ordy[c];
        held[c]  = obs[c];
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; iv = '0; ordy = '0; drv = '0;
    iv[0]  = 1'b1;
    drv[0] = {29'b0, 4'h3, 16'h1234, 8'd0, 3'd1, 2'd1, 2'd0};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      if (!DZ[c]) begin
        check({names[c], ".release_in_ready"}, 64'(irdy[c]), 64'd1);
        check({names[c], ".release_out_valid"}, 64'(ov[c]), 64'd0);
      end
    end
    @(posedge clk); #1;
    iv[0] = 1'b0; ordy[0] = 1'b1;
    @(negedge clk);
    check("a.aw.latency_1", 64'(ov[0]), 64'd1);
    @(posedge clk); #1 ordy[0] = 1'b0;
  endtask

  task automatic test_throughput();
    int idx [2], n_out [2], first_in [2], first_out [2], last_out [2];
    int ch [2] = '{1, 6};
    for (int j = 0; j < 2; j++) begin
      idx[j] = 0; n_out[j] = 0; first_in[j] = -1; first_out[j] = -1; last_out[j] = -1;
      ordy[ch[j]] = 1'b1;
    end
    for (int k = 0; k < 100; k++) begin
      if (n_out[0] == 16 && n_out[1] == 16) break;
      @(posedge clk); #1;
      for (int j = 0; j < 2; j++) begin
        iv[ch[j]] = (idx[j] < 16);
        if (idx[j] < 16) drv[ch[j]] = w_beat(idx[j]);
      end
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        if (iv[ch[j]] && irdy[ch[j]]) begin
          if (idx[j] == 0) first_in[j] = k;
          idx[j]++;
        end
        if (ov[ch[j]] && ordy[ch[j]]) begin
          if (n_out[j] == 0) first_out[j] = k;
          last_out[j] = k;
          n_out[j]++;
        end
      end
    end
    @(posedge clk); #1 iv[1] = 1'b0; iv[6] = 1'b0;
    check("a.w.d2_beats", 64'(n_out[0]), 64'd16);
    check("a.w.d2_latency", 64'(first_out[0] - first_in[0]), 64'd1);
    check("a.w.d2_span", 64'(last_out[0] - first_out[0]), 64'd15);
    check("b.w.d1_beats", 64'(n_out[1]), 64'd16);
    check("b.w.d1_latency", 64'(first_out[1] - first_in[1]), 64'd1);
    check("b.w.d1_span", 64'(last_out[1] - first_out[1]), 64'd30);
  endtask

  task automatic test_ar_backpressure();
    int next = 0;
    int n_out = 0;
    ordy[3] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      iv[3] = 1'b1; drv[3] = ar_beat(next);
      @(negedge clk);
      if (irdy[3]) next++;
    end
    check("a.ar.accepted_when_full", 64'(next), 64'd3);
    check("a.ar.ready_when_full", 64'(irdy[3]), 64'd0);
    for (int k = 0; k < 60; k++) begin
      if (n_out == 13) break;
      @(posedge clk); #1;
      ordy[3] = 1'b1;
      iv[3]   = (next < 13);
      if (next < 13) drv[3] = ar_beat(next);
      @(negedge clk);
      if (iv[3] && irdy[3]) next++;
      if (ov[3] && ordy[3]) n_out++;
    end
    @(posedge clk); #1 iv[3] = 1'b0;
    check("a.ar.total_out", 64'(n_out), 64'd13);
    check("a.ar.sb_empty", 64'(sb_q[3].size()), 64'd0);
  endtask

  task automatic test_id();
    ordy[0] = 1'b0;
    @(posedge clk); #1;
    iv[0] = 1'b1; drv[0] = {29'b0, 4'hA, 16'hBEEF, 8'd3, 3'd2, 2'd1, 2'd2};
    @(posedge clk); #1 iv[0] = 1'b0;
    @(negedge clk);
    check("a.aw.valid_for_id", 64'(ov[0]), 64'd1);
    check("a.aw.id_widen", 64'(s_a.aw_id), 64'h0A);
    @(posedge clk); #1;
    ordy[0] = 1'b1;
    ordy[2] = 1'b1; iv[2] = 1'b1; drv[2] = {54'b0, 6'h35, 2'b10, 2'b01};
    @(negedge clk);
    check("a.b.id_narrow", 64'(m_a.b_id), 64'h5);
    @(posedge clk); #1 iv[2] = 1'b0; ordy[0] = 1'b0;
  endtask

  task automatic rand_cycles(input int n, input int pv, input int pr);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      for (int c = 0; c < 10; c++) begin
        if (!iv[c] || fired_in[c]) begin
          iv[c]  = ($urandom_range(99) < pv);
          drv[c] = {$urandom, $urandom};
        end
        ordy[c] = ($urandom_range(99) < pr);
      end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      for (int c = 0; c < 10; c++) begin
        if (fired_in[c]) iv[c] = 1'b0;
        ordy[c] = 1'b1;
      end
    end
    @(negedge clk);
    for (int c = 0; c < 10; c++) check({names[c], ".drained"}, 64'(sb_q[c].size()), 64'd0);
  endtask

  task automatic test_mid_reset();
    ordy[4] = 1'b0;
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1 iv[4] = 1'b1; drv[4] = r_beat(j);
    end
    @(posedge clk); #1 iv[4] = 1'b0;
    @(negedge clk);
    check("a.r.holding", 64'(ov[4]), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; ordy[4] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("a.r.valid_after_rst", 64'(ov[4]), 64'd0);
      check("a.r.ready_after_rst", 64'(irdy[4]), 64'd1);
    end
    @(posedge clk); #1 iv[4] = 1'b1; drv[4] = r_beat(7);
    @(posedge clk); #1 iv[4] = 1'b0;
    @(negedge clk);
    check("a.r.fresh_beat_valid", 64'(ov[4]), 64'd1);
  endtask

  initial begin
    test_reset();
    test_throughput();
    test_ar_backpressure();
    test_id();
    rand_cycles(2000, 60, 60);
    rand_cycles(500, 90, 30);
    rand_cycles(500, 30, 90);
    drain();
    test_mid_reset();
    drain();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
